// File: rtl/tc_pkg.sv
// Shared definitions for the timer/counter: FSM states, register offsets,
// CTRL field layout and MODE encodings.
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    // Packed so that EN lands on bit 0, MODE on [2:1] and IM on bit 3.
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } tc_ctrl_t;

    function automatic logic [31:0] ctrl_to_word(input tc_ctrl_t c);
        return {28'h0, c};
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes
// and a maskable level interrupt.
module timer_counter
    import tc_pkg::*;
#(
    parameter logic [31:0] PRESET_RST = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:2] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    tc_state_e   state_q;
    tc_state_e   state_d;
    tc_ctrl_t    ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        irq_flag_q;

    logic        flag_set;
    logic        flag_clr;
    logic        fsm_clr_en;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        unused_addr;

    assign unused_addr = ^addr[31:4];
    assign wr_ctrl     = we && (addr[3:2] == OFF_CTRL);
    assign wr_preset   = we && (addr[3:2] == OFF_PRESET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // A count of 0 or 1 both expire on the next CNT cycle, so PRESET=0
    // behaves like PRESET=1 and COUNT never wraps.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        flag_set   = 1'b0;
        flag_clr   = 1'b0;
        fsm_clr_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d  = 32'h0;
                    flag_set = 1'b1;
                    state_d  = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_q.mode == MODE_RELOAD) begin
                    flag_clr = 1'b1;
                end else begin
                    fsm_clr_en = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The bus write takes priority over the FSM dropping EN in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else if (wr_ctrl) begin
            ctrl_q <= tc_ctrl_t'(din[3:0]);
        end else if (fsm_clr_en) begin
            ctrl_q.en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset_q <= PRESET_RST;
        end else if (wr_preset) begin
            preset_q <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_flag_q <= 1'b0;
        end else if (wr_ctrl) begin
            irq_flag_q <= 1'b0;
        end else if (flag_set) begin
            irq_flag_q <= 1'b1;
        end else if (flag_clr) begin
            irq_flag_q <= 1'b0;
        end
    end

    assign irq = irq_flag_q && ctrl_q.im;

    always_comb begin
        dout = 32'h0;
        case (addr[3:2])
            OFF_CTRL:   dout = ctrl_to_word(ctrl_q);
            OFF_PRESET: dout = preset_q;
            OFF_COUNT:  dout = count_q;
            default:    dout = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: one-shot, auto-reload,
// masking, mid-count changes, reset abort and illegal accesses.
module tb_timer_counter;
    import tc_pkg::*;

    localparam logic [31:0] BASE = 32'h7f00;

    logic        clk;
    logic        rst_n;
    logic [31:2] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    timer_counter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkReg(input logic [1:0] off, input logic [31:0] expected,
                            input string tag);
        addr = 30'(BASE >> 2) + 30'(off);
        #1;
        checkOutput(tag, dout, expected);
    endtask

    task automatic checkIrq(input logic expected, input string tag);
        checkOutput(tag, {31'b0, irq}, {31'b0, expected});
    endtask

    // One bus write committed on the next rising edge; returns just after it.
    task automatic applyStimulus(input logic [1:0] off, input logic [31:0] data);
        addr = 30'(BASE >> 2) + 30'(off);
        din  = data;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        repeat (2) tick();
        checkReg(OFF_CTRL,   32'h0, "rst_ctrl");
        checkReg(OFF_PRESET, 32'h0, "rst_preset");
        checkReg(OFF_COUNT,  32'h0, "rst_count");
        checkIrq(1'b0, "rst_irq");
        rst_n = 1'b1;
        tick();
        checkReg(OFF_CTRL, 32'h0, "post_rst_ctrl");

        // One-shot, PRESET=5: COUNT 5..0 after E2..E7, irq after E7
        applyStimulus(OFF_PRESET, 32'd5);
        applyStimulus(OFF_CTRL, 32'h9);
        tick();
        tick();
        for (int k = 5; k >= 0; k--) begin
            checkReg(OFF_COUNT, 32'(k), "oneshot_count");
            checkIrq(k == 0, "oneshot_irq");
            if (k != 0) tick();
        end
        tick();
        checkReg(OFF_CTRL, 32'h8, "oneshot_en_cleared");
        checkIrq(1'b1, "oneshot_irq_held");
        repeat (3) tick();
        checkIrq(1'b1, "oneshot_irq_level");
        applyStimulus(OFF_CTRL, 32'h8);
        checkIrq(1'b0, "oneshot_irq_ctrl_clear");
        checkReg(OFF_COUNT, 32'h0, "oneshot_count_final");

        // Auto-reload, PRESET=3: one-cycle pulse after E5, E11, E17
        applyStimulus(OFF_PRESET, 32'd3);
        applyStimulus(OFF_CTRL, 32'hB);
        for (int k = 1; k <= 18; k++) begin
            tick();
            checkIrq((k % 6) == 5, "reload_irq");
        end
        checkReg(OFF_CTRL, 32'hB, "reload_en_kept");
        applyStimulus(OFF_CTRL, 32'h0);
        repeat (3) tick();
        checkIrq(1'b0, "reload_stopped_irq");

        // Masking, PRESET=2 with IM=0
        applyStimulus(OFF_PRESET, 32'd2);
        applyStimulus(OFF_CTRL, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            checkIrq(1'b0, "mask_irq");
        end
        checkReg(OFF_CTRL, 32'h0, "mask_en_cleared");
        applyStimulus(OFF_CTRL, 32'h9);
        checkIrq(1'b0, "mask_unmask_irq");
        checkReg(OFF_CTRL, 32'h9, "mask_ctrl");
        tick();
        checkIrq(1'b0, "mask_unmask_irq2");
        applyStimulus(OFF_CTRL, 32'h8);
        repeat (2) tick();

        // Mid-count PRESET change and disable
        applyStimulus(OFF_PRESET, 32'd10);
        applyStimulus(OFF_CTRL, 32'h9);
        repeat (4) tick();
        checkReg(OFF_COUNT, 32'd8, "mid_count_e4");
        applyStimulus(OFF_PRESET, 32'd100);
        checkReg(OFF_COUNT, 32'd7, "mid_count_unaffected");
        checkReg(OFF_PRESET, 32'd100, "mid_preset_rd");
        applyStimulus(OFF_CTRL, 32'h8);
        checkReg(OFF_COUNT, 32'd6, "mid_count_last_dec");
        repeat (4) begin
            tick();
            checkReg(OFF_COUNT, 32'd6, "mid_count_frozen");
            checkIrq(1'b0, "mid_irq");
        end
        applyStimulus(OFF_CTRL, 32'h9);
        tick();
        tick();
        checkReg(OFF_COUNT, 32'd100, "mid_reload_100");

        // Reset asserted with COUNT=7
        repeat (93) tick();
        checkReg(OFF_COUNT, 32'd7, "pre_rst_count");
        rst_n = 1'b0;
        #1;
        checkReg(OFF_CTRL,   32'h0, "arst_ctrl");
        checkReg(OFF_PRESET, 32'h0, "arst_preset");
        checkReg(OFF_COUNT,  32'h0, "arst_count");
        checkIrq(1'b0, "arst_irq");
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checkReg(OFF_COUNT, 32'h0, "idle_count");
            checkIrq(1'b0, "idle_irq");
        end
        checkReg(OFF_CTRL, 32'h0, "idle_ctrl");

        // Illegal accesses and bus-write priority over FSM EN clear
        applyStimulus(OFF_PRESET, 32'd4);
        applyStimulus(OFF_COUNT, 32'h1234);
        checkReg(OFF_COUNT, 32'h0, "ill_count_ro");
        applyStimulus(OFF_RSVD, 32'hDEAD);
        checkReg(OFF_RSVD,   32'h0, "ill_rsvd_rd");
        checkReg(OFF_CTRL,   32'h0, "ill_ctrl_untouched");
        checkReg(OFF_PRESET, 32'd4, "ill_preset_untouched");
        checkReg(OFF_COUNT,  32'h0, "ill_count_untouched");
        applyStimulus(OFF_CTRL, 32'hFFFF_FFFF);
        checkReg(OFF_CTRL, 32'hF, "ill_ctrl_mask");
        for (int k = 1; k <= 6; k++) begin
            tick();
            checkIrq(k == 6, "mode3_irq");
        end
        applyStimulus(OFF_CTRL, 32'hFFFF_FFFF);
        checkReg(OFF_CTRL, 32'hF, "bus_wins_en");
        checkIrq(1'b0, "bus_wins_irq");
        applyStimulus(OFF_CTRL, 32'h0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL have parameter PRESET_RST, default 32'h0, the reset value of PRESET.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset; asynchronous and active-low.
REQ-004 The block SHALL have port addr, input, 30 bits ([31:2]), the word address; only addr[3:2] is decoded.
REQ-005 The block SHALL have port we, input, 1 bit, the write strobe, already qualified by the system bridge address decode and interrupt gating.
REQ-006 The block SHALL have port din, input, 32 bits, the write data.
REQ-007 The block SHALL have port dout, output, 32 bits, the read data.
REQ-008 The block SHALL have port irq, output, 1 bit, the level interrupt request.

Function
REQ-009 The register map SHALL decode addr[3:2] as follows: 0=CTRL (read/write), 1=PRESET (read/write), 2=COUNT (read-only; writes ignored), 3=reserved (reads 0, writes ignored).
REQ-010 CTRL SHALL have these fields: bit 0 EN, bits [2:1] MODE, bit 3 IM (interrupt mask); bits [31:4] SHALL read 0 and ignore writes.
REQ-011 dout SHALL be a combinational mux of the register selected by addr[3:2], with no read latency.
REQ-012 The FSM SHALL have the states IDLE, LOAD, CNT and INT.
REQ-013 In IDLE, the FSM SHALL go to LOAD if EN=1 and otherwise stay in IDLE; COUNT SHALL hold.
REQ-014 In LOAD, the FSM SHALL set COUNT<=PRESET and go to CNT.
REQ-015 In CNT with EN=0, the FSM SHALL go to IDLE and COUNT SHALL hold.
REQ-016 In CNT with COUNT>1, the FSM SHALL set COUNT<=COUNT-1.
REQ-017 In CNT with COUNT<=1, the FSM SHALL set COUNT<=0 and irq_flag<=1, and go to INT.
REQ-018 In INT with MODE=1, the FSM SHALL set irq_flag<=0 and go to IDLE; EN stays 1, so the counter auto-reloads with period PRESET+3 cycles.
REQ-019 In INT with MODE 0, 2 or 3, the FSM SHALL set EN<=0, keep irq_flag set, and go to IDLE.
REQ-020 irq SHALL equal irq_flag AND IM.
REQ-021 Any CTRL write SHALL clear irq_flag.
REQ-022 When a bus write to CTRL and an FSM clear of EN occur in the same cycle, the bus write SHALL win.
REQ-023 A PRESET write during CNT SHALL not affect the current COUNT; it SHALL take effect at the next LOAD.
REQ-024 Latency: with a CTRL write of EN=1 at edge E0, LOAD SHALL occur at E1, COUNT=PRESET SHALL hold after E2, and irq SHALL rise after edge E0+PRESET+2 (for PRESET>=1).
REQ-025 PRESET=0 SHALL behave like PRESET=1, and irq SHALL rise after E0+3.
REQ-026 Arithmetic SHALL be 32-bit unsigned, and COUNT SHALL never wrap below 0.

Reset
REQ-027 When rst_n=0, the block SHALL immediately set state=IDLE, CTRL=0, PRESET=PRESET_RST, COUNT=0 and irq_flag=0, with irq=0 combinationally.
REQ-028 Reset asserted mid-count SHALL abort without generating irq, and after release the block SHALL stay idle until EN is written.
REQ-029 Release of rst_n SHALL be synchronised externally, and the block SHALL not generate any spurious transition in the first cycle after release.

Structure
REQ-030 The shared package tc_pkg SHALL hold the FSM state enum, the register offsets (CTRL/PRESET/COUNT) and the MODE encodings.
REQ-031 The block SHALL be a single module with no sub-module, and two instances SHALL be placed at 0x7f00 and 0x7f10 in the bridge address space.

Verification
REQ-032 The bench SHALL check one-shot: PRESET=5, then CTRL=0x9 (EN, mode0, IM) at E0 -> COUNT reads 5,4,3,2,1,0; irq rises after E7 and stays high; EN reads 0 afterwards; a CTRL write of 0x8 drops irq.
REQ-033 The bench SHALL check auto-reload: PRESET=3, CTRL=0xB -> irq is a 1-cycle pulse every 6 cycles; EN remains 1.
REQ-034 The bench SHALL check masking: PRESET=2, CTRL=0x1 -> irq stays 0; after expiry, setting IM while keeping EN=1 still leaves irq 0 because the CTRL write clears irq_flag.
REQ-035 The bench SHALL check a mid-count change: during CNT, write PRESET=100 and then CTRL EN=0 -> COUNT freezes and irq stays 0; re-enabling reloads COUNT with 100.
REQ-036 The bench SHALL check reset mid-operation: assert rst_n=0 at COUNT=7 -> all registers read 0 and irq=0 immediately; after release, no activity occurs for 20 cycles.
REQ-037 The bench SHALL check illegal accesses: a write to COUNT or offset 3 changes nothing; a read of offset 3 returns 0; a write of CTRL=0xFFFFFFFF reads back 0xF.
